// File: rtl/pcm_dac4_modulator_pkg.sv
// Shared audio definitions: default sample/ladder widths, the ladder midscale
// code and the two's-complement to offset-binary conversion used at intake.
package audio_pkg;

    localparam int PCM_BITS_DEF = 12;
    localparam int DAC_BITS_DEF = 4;

    // Ladder code for silence: half of full scale.
    localparam logic [DAC_BITS_DEF-1:0] DAC_MIDSCALE = {1'b1, {(DAC_BITS_DEF-1){1'b0}}};

    // Signed sample to unsigned offset binary: flipping the sign bit maps
    // -2^(N-1) to 0 and +2^(N-1)-1 to full scale.
    function automatic logic [PCM_BITS_DEF-1:0] to_offset_binary(input logic [PCM_BITS_DEF-1:0] pcm);
        return {~pcm[PCM_BITS_DEF-1], pcm[PCM_BITS_DEF-2:0]};
    endfunction

endpackage

// File: rtl/pcm_dac4_modulator_if.sv
// PCM sample stream with valid/ready handshake between a waveform source
// (master) and the DAC modulator (slave).
interface pcm_dac4_modulator_if #(
    parameter int PCM_BITS = 12
);
    logic [PCM_BITS-1:0] pcm;
    logic                pcm_valid;
    logic                pcm_ready;

    modport master (output pcm, output pcm_valid, input pcm_ready);
    modport slave  (input pcm, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pcm_dac4_modulator_sigma_delta.sv
// First-order error-feedback requantiser: on each tick the residue of the
// previous requantisation is added back before truncating to the ladder width,
// so the average ladder code tracks the full-precision sample.
module dac4_sigma_delta
    import audio_pkg::*;
#(
    parameter int PCM_BITS = PCM_BITS_DEF,
    parameter int DAC_BITS = DAC_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                clr_i,
    input  logic [PCM_BITS-1:0] active_i,
    output logic [DAC_BITS-1:0] dac_out_o
);

    localparam int ERR_W = PCM_BITS - DAC_BITS;

    logic [DAC_BITS-1:0] dac_q, dac_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [PCM_BITS:0]   sum_s;

    assign sum_s     = {1'b0, active_i} + {{(DAC_BITS + 1){1'b0}}, err_q};
    assign dac_out_o = dac_q;

    // Next ladder code and residue: mute clears, tick requantises, else hold.
    always_comb begin
        dac_d = dac_q;
        err_d = err_q;
        if (clr_i) begin
            dac_d = DAC_MIDSCALE;
            err_d = '0;
        end else if (tick_i) begin
            if (sum_s[PCM_BITS]) begin
                // Overflow only happens near full-scale positive; pin to top code.
                dac_d = '1;
                err_d = '1;
            end else begin
                dac_d = sum_s[PCM_BITS-1 -: DAC_BITS];
                err_d = sum_s[ERR_W-1:0];
            end
        end else begin
            dac_d = dac_q;
            err_d = err_q;
        end
    end

    // Ladder code and residue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_q <= DAC_MIDSCALE;
            err_q <= '0;
        end else begin
            dac_q <= dac_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/pcm_dac4_modulator.sv
// PCM to 4-bit ladder DAC modulator: one-deep sample buffer with valid/ready
// intake, modulator tick and audio sample tick generation, and an
// error-feedback requantiser driving the ladder pins.
module pcm_dac4_modulator
    import audio_pkg::*;
#(
    parameter int PCM_BITS   = PCM_BITS_DEF,
    parameter int DAC_BITS   = DAC_BITS_DEF,
    parameter int MOD_DIV    = 4,
    parameter int SAMPLE_DIV = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    pcm_dac4_modulator_if.slave   pcm_if,
    output logic [DAC_BITS-1:0]   dac_out_o,
    output logic                  underrun_o
);

    localparam int MOD_W = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
    localparam int SMP_W = $clog2(SAMPLE_DIV);
    localparam logic [MOD_W-1:0]    MOD_LAST   = MOD_W'(MOD_DIV - 1);
    localparam logic [SMP_W-1:0]    SMP_LAST   = SMP_W'(SAMPLE_DIV - 1);
    localparam logic [PCM_BITS-1:0] ACTIVE_MID = {1'b1, {(PCM_BITS-1){1'b0}}};

    logic [MOD_W-1:0]    mod_cnt_q, mod_cnt_d;
    logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic [PCM_BITS-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [PCM_BITS-1:0] active_q, active_d;
    logic                ready_q, ready_d;
    logic                underrun_q, underrun_d;
    logic                tick_s;
    logic                sample_tick_s;
    logic                intake_s;

    assign tick_s         = enable_i && (mod_cnt_q == MOD_LAST);
    assign sample_tick_s  = tick_s && (smp_cnt_q == SMP_LAST);
    assign intake_s       = pcm_if.pcm_valid && ready_q;
    assign pcm_if.pcm_ready = ready_q;
    assign underrun_o     = underrun_q;

    // Tick counters, buffer hand-over to the active sample, and intake.
    always_comb begin
        mod_cnt_d   = mod_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        active_d    = active_q;
        underrun_d  = 1'b0;

        if (!enable_i) begin
            mod_cnt_d = '0;
            smp_cnt_d = '0;
        end else if (tick_s) begin
            mod_cnt_d = '0;
            if (sample_tick_s) begin
                smp_cnt_d = '0;
            end else begin
                smp_cnt_d = smp_cnt_q + SMP_W'(1);
            end
        end else begin
            mod_cnt_d = mod_cnt_q + MOD_W'(1);
        end

        // An empty buffer at the sample boundary repeats the last sample.
        if (sample_tick_s) begin
            if (hold_full_q) begin
                active_d    = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d  = 1'b1;
            end
        end else begin
            active_d = active_q;
        end

        // A new sample always lands in the buffer, never straight into active.
        if (intake_s) begin
            hold_d      = to_offset_binary(pcm_if.pcm);
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        ready_d = enable_i && !hold_full_d;
    end

    // Counter, buffer and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            active_q    <= ACTIVE_MID;
            ready_q     <= 1'b1;
            underrun_q  <= 1'b0;
        end else begin
            mod_cnt_q   <= mod_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            active_q    <= active_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
        end
    end

    dac4_sigma_delta #(
        .PCM_BITS (PCM_BITS),
        .DAC_BITS (DAC_BITS)
    ) u_sigma_delta (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick_s),
        .clr_i     (!enable_i),
        .active_i  (active_q),
        .dac_out_o (dac_out_o)
    );

endmodule

// File: tb/tb_pcm_dac4_modulator.sv
// Bench for pcm_dac4_modulator: randomized and directed stimulus checked every
// clock against an arithmetic reference model of sample buffering, tick timing
// and error-feedback requantisation.
module tb_pcm_dac4_modulator;

    localparam int PB = 12;
    localparam int DB = 4;
    localparam int MD = 2;
    localparam int SD = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [DB-1:0] dac_out;
    logic          underrun;

    pcm_dac4_modulator_if #(.PCM_BITS(PB)) pif();

    pcm_dac4_modulator #(
        .PCM_BITS   (PB),
        .DAC_BITS   (DB),
        .MOD_DIV    (MD),
        .SAMPLE_DIV (SD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable),
        .pcm_if     (pif.slave),
        .dac_out_o  (dac_out),
        .underrun_o (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, in plain integers.
    int m_hold, m_full, m_active, m_err, m_dac, m_ready, m_under, m_cyc;
    bit m_tick;
    bit acc_on = 1'b0;
    int dut_sum = 0;
    int dut_ticks = 0;
    int dut_under = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_full = 0; m_active = 2048; m_err = 0;
        m_dac = 8; m_ready = 1; m_under = 0; m_cyc = 0; m_tick = 1'b0;
    endtask

    function automatic bit next_is_sample_tick();
        return ((m_cyc % MD) == MD - 1) && (((m_cyc / MD) % SD) == SD - 1);
    endfunction

    // One clock: capture inputs, advance model at the edge, compare after it.
    task automatic step();
        int v_pcm, s, old_active;
        bit v_valid, v_en, st, intake;
        v_pcm   = $signed(pif.pcm);
        v_valid = pif.pcm_valid;
        v_en    = enable;
        @(posedge clk);
        intake = v_valid && (m_ready != 0);
        m_tick = 1'b0;
        if (!v_en) begin
            if (intake) begin m_hold = v_pcm + 2048; m_full = 1; end
            m_dac = 8; m_err = 0; m_cyc = 0; m_ready = 0; m_under = 0;
        end else begin
            m_tick = ((m_cyc % MD) == MD - 1);
            st = next_is_sample_tick();
            old_active = m_active;
            m_under = (st && m_full == 0) ? 1 : 0;
            if (st && m_full != 0) begin m_active = m_hold; m_full = 0; end
            if (intake) begin m_hold = v_pcm + 2048; m_full = 1; end
            if (m_tick) begin
                s = old_active + m_err;
                if (s >= 4096) begin m_dac = 15; m_err = 255; end
                else begin m_dac = s / 256; m_err = s % 256; end
            end
            m_cyc++;
            m_ready = (m_full == 0) ? 1 : 0;
        end
        #1;
        chk("dac_out", dac_out, m_dac);
        chk("pcm_ready", pif.pcm_ready, m_ready);
        chk("underrun", underrun, m_under);
        if (underrun === 1'b1) dut_under++;
        if (acc_on && m_tick) begin dut_sum += dac_out; dut_ticks++; end
    endtask

    task automatic run_const(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            pif.pcm = 12'(p);
            pif.pcm_valid = 1'b1;
            step();
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            pif.pcm = 12'($urandom);
            pif.pcm_valid = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 49) != 0);
            step();
        end
        enable = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dac"}, dac_out, 8);
        chk({tag, "_ready"}, pif.pcm_ready, 1);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        pif.pcm = '0;
        pif.pcm_valid = 1'b0;
        model_reset();

        // Reset holds outputs regardless of inputs.
        for (int i = 0; i < 4; i++) begin
            pif.pcm = 12'($urandom);
            pif.pcm_valid = $urandom_range(0, 1);
            enable = $urandom_range(0, 1);
            #7;
            check_reset_outputs("reset");
        end
        @(negedge clk);
        pif.pcm_valid = 1'b0;
        enable = 1'b1;
        rst_n = 1'b1;

        // DC levels: midscale, bottom, saturated top.
        run_const(0, 4 * MD * SD);
        chk("dc_zero", dac_out, 8);
        run_const(-2048, 4 * MD * SD);
        chk("dc_neg_full", dac_out, 0);
        run_const(2047, 4 * MD * SD);
        chk("dc_pos_sat", dac_out, 15);

        // Dither: 0x880 active alternates 8/9, mean 8.5 over a sample period.
        run_const(128, 2 * MD * SD);
        acc_on = 1'b1; dut_sum = 0; dut_ticks = 0;
        run_const(128, MD * SD);
        acc_on = 1'b0;
        chk("dither_ticks", dut_ticks, SD);
        chk("dither_sum_x2", 2 * dut_sum, 17 * SD);

        // Underrun: flush the buffer, then count one pulse per sample period.
        pif.pcm_valid = 1'b0;
        for (int i = 0; i < MD * SD; i++) step();
        dut_under = 0;
        for (int i = 0; i < 3 * MD * SD; i++) step();
        chk("underrun_count", dut_under, 3);
        run_const(-1000, MD * SD);
        dut_under = 0;
        run_const(-1000, 2 * MD * SD);
        chk("resume_no_underrun", dut_under, 0);

        // Collision: value changes exactly on the sample boundary.
        run_const(-2048, 2 * MD * SD);
        begin
            int guard = 0;
            while (!next_is_sample_tick() && guard < MD * SD + 2) begin
                run_const(-2048, 1);
                guard++;
            end
            chk("collision_sync", next_is_sample_tick(), 1);
        end
        run_const(1500, 2);
        chk("collision_ready", pif.pcm_ready, 0);
        run_const(1500, MD * SD - 4);
        chk("collision_ready_hold", pif.pcm_ready, 0);
        chk("collision_old_active", dac_out, 0);
        run_const(1500, 2 * MD * SD);

        // Mute mid-run.
        enable = 1'b0;
        run_const(700, 1);
        chk("mute_dac", dac_out, 8);
        chk("mute_ready", pif.pcm_ready, 0);
        run_const(700, 10);
        enable = 1'b1;
        run_const(700, 3 * MD * SD);

        // Random traffic with a reset pulse in the middle of a sample.
        run_random(700);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_random(1200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
